// File: rtl/bht_gshare_predictor_pkg.sv
// Shared constants and helpers for the gshare/bimodal branch direction predictor.
package bht_gshare_predictor_pkg;

    // Fetch group geometry: four consecutive slots starting at the group PC.
    localparam int FETCH_W = 4;
    localparam int SEL_W   = 2;

    // Default table / history / counter sizing.
    localparam int DEF_IDX_W  = 6;
    localparam int DEF_HIST_W = 6;
    localparam int DEF_CNT_W  = 2;

    // Encodings of a 2-bit saturating direction counter.
    localparam logic [1:0] CNT_SN = 2'd0;  // strongly not-taken
    localparam logic [1:0] CNT_WN = 2'd1;  // weakly not-taken
    localparam logic [1:0] CNT_WT = 2'd2;  // weakly taken
    localparam logic [1:0] CNT_ST = 2'd3;  // strongly taken

    // Registered prediction bundle (history is carried separately because its
    // width is a parameter of the top).
    typedef struct packed {
        logic               vld;
        logic [FETCH_W-1:0] taken;
        logic [SEL_W-1:0]   sel;
        logic               any;
    } pred_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [FETCH_W-1:0] v);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = FETCH_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = SEL_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bht_gshare_predictor_sat_counter_update.sv
// Combinational saturating increment/decrement of one direction counter.
module sat_counter_update #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Move one step toward the outcome, holding at the all-ones / all-zeros rails.
    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != '1) begin
                cnt_o = cnt_i + CNT_W'(1);
            end
        end else begin
            if (cnt_i != '0) begin
                cnt_o = cnt_i - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bht_gshare_predictor.sv
// Table of saturating direction counters indexed by PC (bimodal) or
// PC XOR global history (gshare). Predicts a 4-slot fetch group one cycle
// after lookup and trains at commit, restoring history on a mispredict.
//
// Interface semantics: lookup_vld_i and upd_vld_i are single-cycle valid
// strobes with no ready; both are accepted every cycle. pred_vld_o is
// lookup_vld_i delayed by one cycle and all pred outputs read 0 when it is low.
module bht_gshare_predictor
    import bht_gshare_predictor_pkg::*;
#(
    parameter int IDX_W    = DEF_IDX_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int HIST_W   = DEF_HIST_W,
    parameter int MODE     = 1,
    parameter int CNT_INIT = 1 << (CNT_W - 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               lookup_vld_i,
    input  logic [15:0]        lookup_pc_i,
    input  logic [3:0]         lookup_brnch_mask_i,
    output logic               pred_vld_o,
    output logic [3:0]         pred_taken_o,
    output logic [1:0]         pred_sel_o,
    output logic               pred_any_taken_o,
    output logic [HIST_W-1:0]  pred_ghr_o,
    input  logic               upd_vld_i,
    input  logic [15:0]        upd_pc_i,
    input  logic [HIST_W-1:0]  upd_ghr_i,
    input  logic               upd_taken_i,
    input  logic               upd_mispredict_i
);

    localparam int                DEPTH      = 1 << IDX_W;
    localparam logic [CNT_W-1:0]  CNT_INIT_V = CNT_W'(CNT_INIT);

    // Only the low IDX_W PC bits select a counter; a 16-bit wrapping add
    // and an IDX_W-bit wrapping add agree on those bits.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i[15:IDX_W], upd_pc_i[15:IDX_W]};

    // Counter table and global history.
    logic [CNT_W-1:0]  cnt_q [DEPTH];
    logic [HIST_W-1:0] ghr_q;
    logic [HIST_W-1:0] ghr_d;

    // Registered prediction.
    pred_t             pred_q;
    pred_t             pred_d;
    logic [HIST_W-1:0] pred_ghr_q;
    logic [HIST_W-1:0] pred_ghr_d;

    // Lookup path.
    logic [IDX_W-1:0]   slot_idx [FETCH_W];
    logic [FETCH_W-1:0] taken_comb;
    logic               any_comb;
    logic [SEL_W-1:0]   sel_comb;

    // Update path.
    logic [IDX_W-1:0] upd_idx;
    logic [CNT_W-1:0] upd_cnt_cur;
    logic [CNT_W-1:0] upd_cnt_new;

    // Counter index: history is ignored in bimodal mode, XORed in gshare mode.
    function automatic logic [IDX_W-1:0] table_index(
        input logic [IDX_W-1:0]  pc_lo,
        input logic [HIST_W-1:0] hist
    );
        logic [IDX_W-1:0] hist_ext;
        hist_ext = IDX_W'(hist);
        if (MODE == 1) begin
            return pc_lo ^ hist_ext;
        end
        return pc_lo;
    endfunction

    // Shift one outcome bit into a history value, dropping the oldest bit.
    function automatic logic [HIST_W-1:0] shift_in(
        input logic [HIST_W-1:0] hist,
        input logic              b
    );
        return HIST_W'({hist, b});
    endfunction

    // Per-slot table read; slots that alias to one entry simply share it.
    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            slot_idx[i]   = table_index(lookup_pc_i[IDX_W-1:0] + IDX_W'(i), ghr_q);
            taken_comb[i] = cnt_q[slot_idx[i]][CNT_W-1] & lookup_brnch_mask_i[i];
        end
    end

    assign any_comb = |taken_comb;
    assign sel_comb = lowest_set(taken_comb);

    // Next prediction: zeros unless a group is being looked up.
    always_comb begin
        pred_d     = '0;
        pred_ghr_d = '0;
        if (lookup_vld_i) begin
            pred_d.vld   = 1'b1;
            pred_d.taken = taken_comb;
            pred_d.sel   = sel_comb;
            pred_d.any   = any_comb;
            pred_ghr_d   = ghr_q;
        end
    end

    // Next history: mispredict recovery wins over the speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_vld_i && upd_mispredict_i) begin
            ghr_d = shift_in(upd_ghr_i, upd_taken_i);
        end else if (lookup_vld_i && (|lookup_brnch_mask_i)) begin
            ghr_d = shift_in(ghr_q, any_comb);
        end
    end

    // Training index uses the history captured with the branch, not the live one.
    assign upd_idx     = table_index(upd_pc_i[IDX_W-1:0], upd_ghr_i);
    assign upd_cnt_cur = cnt_q[upd_idx];

    sat_counter_update #(
        .CNT_W (CNT_W)
    ) u_sat (
        .cnt_i (upd_cnt_cur),
        .inc_i (upd_taken_i),
        .cnt_o (upd_cnt_new)
    );

    // Counter table write; a same-cycle lookup already read the old value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int e = 0; e < DEPTH; e++) begin
                cnt_q[e] <= CNT_INIT_V;
            end
        end else if (upd_vld_i) begin
            cnt_q[upd_idx] <= upd_cnt_new;
        end
    end

    // History and prediction registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr_q      <= '0;
            pred_q     <= '0;
            pred_ghr_q <= '0;
        end else begin
            ghr_q      <= ghr_d;
            pred_q     <= pred_d;
            pred_ghr_q <= pred_ghr_d;
        end
    end

    assign pred_vld_o       = pred_q.vld;
    assign pred_taken_o     = pred_q.taken;
    assign pred_sel_o       = pred_q.sel;
    assign pred_any_taken_o = pred_q.any;
    assign pred_ghr_o       = pred_ghr_q;

endmodule

// File: tb/tb_bht_gshare_predictor.sv
// Bench for bht_gshare_predictor: one bimodal and one gshare instance share
// the same stimulus and are compared against a table/history model.
module tb_bht_gshare_predictor;

    logic        clk;
    logic        rst;
    logic        lookup_vld;
    logic [15:0] lookup_pc;
    logic [3:0]  lookup_mask;
    logic        upd_vld;
    logic [15:0] upd_pc;
    logic [5:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mis;

    logic        b_vld, g_vld;
    logic [3:0]  b_taken, g_taken;
    logic [1:0]  b_sel, g_sel;
    logic        b_any, g_any;
    logic [5:0]  b_ghr, g_ghr;

    int total = 0;
    int bad   = 0;

    // Reference model: [0] = bimodal, [1] = gshare.
    int tbl_m [2][64];
    int ghr_m [2];
    int e_vld [2];
    int e_tk  [2];
    int e_sel [2];
    int e_any [2];
    int e_ghr [2];

    bht_gshare_predictor #(.MODE(0)) dut_b (
        .clk_i               (clk),
        .rst_i               (rst),
        .lookup_vld_i        (lookup_vld),
        .lookup_pc_i         (lookup_pc),
        .lookup_brnch_mask_i (lookup_mask),
        .pred_vld_o          (b_vld),
        .pred_taken_o        (b_taken),
        .pred_sel_o          (b_sel),
        .pred_any_taken_o    (b_any),
        .pred_ghr_o          (b_ghr),
        .upd_vld_i           (upd_vld),
        .upd_pc_i            (upd_pc),
        .upd_ghr_i           (upd_ghr),
        .upd_taken_i         (upd_taken),
        .upd_mispredict_i    (upd_mis)
    );

    bht_gshare_predictor #(.MODE(1)) dut_g (
        .clk_i               (clk),
        .rst_i               (rst),
        .lookup_vld_i        (lookup_vld),
        .lookup_pc_i         (lookup_pc),
        .lookup_brnch_mask_i (lookup_mask),
        .pred_vld_o          (g_vld),
        .pred_taken_o        (g_taken),
        .pred_sel_o          (g_sel),
        .pred_any_taken_o    (g_any),
        .pred_ghr_o          (g_ghr),
        .upd_vld_i           (upd_vld),
        .upd_pc_i            (upd_pc),
        .upd_ghr_i           (upd_ghr),
        .upd_taken_i         (upd_taken),
        .upd_mispredict_i    (upd_mis)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ghr_m[m] = 0;
            for (int e = 0; e < 64; e++) tbl_m[m][e] = 2;
        end
    endtask

    // One clock: drive, predict with the model, advance the model, compare.
    task automatic step(input bit r, input bit lv, input logic [15:0] pc, input logic [3:0] mask,
                        input bit uv, input logic [15:0] upc, input logic [5:0] ughr,
                        input bit ut, input bit um);
        logic [15:0] spc;
        int idx;
        rst = r; lookup_vld = lv; lookup_pc = pc; lookup_mask = mask;
        upd_vld = uv; upd_pc = upc; upd_ghr = ughr; upd_taken = ut; upd_mis = um;
        for (int m = 0; m < 2; m++) begin
            e_vld[m] = 0; e_tk[m] = 0; e_sel[m] = 0; e_any[m] = 0; e_ghr[m] = 0;
            if (!r && lv) begin
                e_vld[m] = 1;
                e_ghr[m] = ghr_m[m];
                for (int i = 0; i < 4; i++) begin
                    spc = pc + 16'(i);
                    idx = int'(spc) % 64;
                    if (m == 1) idx = idx ^ ghr_m[m];
                    if (mask[i] && tbl_m[m][idx] >= 2) e_tk[m] += (1 << i);
                end
                for (int i = 3; i >= 0; i--) if ((e_tk[m] >> i) % 2 == 1) e_sel[m] = i;
                e_any[m] = (e_tk[m] != 0) ? 1 : 0;
            end
        end
        if (r) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (uv) begin
                    idx = int'(upc) % 64;
                    if (m == 1) idx = idx ^ int'(ughr);
                    if (ut) tbl_m[m][idx] = (tbl_m[m][idx] < 3) ? tbl_m[m][idx] + 1 : 3;
                    else    tbl_m[m][idx] = (tbl_m[m][idx] > 0) ? tbl_m[m][idx] - 1 : 0;
                end
                if (uv && um)               ghr_m[m] = (int'(ughr) * 2 + int'(ut)) % 64;
                else if (lv && mask != 4'd0) ghr_m[m] = (ghr_m[m] * 2 + e_any[m]) % 64;
            end
        end
        @(posedge clk);
        #1;
        chk("b.vld",   16'(b_vld),   16'(e_vld[0]));
        chk("b.taken", 16'(b_taken), 16'(e_tk[0]));
        chk("b.sel",   16'(b_sel),   16'(e_sel[0]));
        chk("b.any",   16'(b_any),   16'(e_any[0]));
        chk("b.ghr",   16'(b_ghr),   16'(e_ghr[0]));
        chk("g.vld",   16'(g_vld),   16'(e_vld[1]));
        chk("g.taken", 16'(g_taken), 16'(e_tk[1]));
        chk("g.sel",   16'(g_sel),   16'(e_sel[1]));
        chk("g.any",   16'(g_any),   16'(e_any[1]));
        chk("g.ghr",   16'(g_ghr),   16'(e_ghr[1]));
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
    endtask

    task automatic look(input logic [15:0] pc, input logic [3:0] mask);
        step(1'b0, 1'b1, pc, mask, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [15:0] pc, input logic [5:0] ghr, input bit t);
        step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1, pc, ghr, t, 1'b0);
    endtask

    initial begin
        model_reset();
        // Reset state
        do_reset();
        chk("rst.b_vld", 16'(b_vld), 16'd0);
        chk("rst.g_ghr", 16'(g_ghr), 16'd0);

        // First lookup after reset: weakly-taken counters
        look(16'h0010, 4'b0001);
        chk("first.vld",   16'(b_vld),   16'd1);
        chk("first.taken", 16'(g_taken), 16'b0001);
        chk("first.sel",   16'(g_sel),   16'd0);
        chk("first.any",   16'(b_any),   16'd1);
        chk("first.ghr",   16'(g_ghr),   16'd0);

        // Bimodal training: floor and cap
        upd(16'h0010, 6'd0, 1'b0);
        upd(16'h0010, 6'd0, 1'b0);
        upd(16'h0010, 6'd0, 1'b0);
        look(16'h0010, 4'b0001);
        chk("bim.nt3", 16'(b_taken), 16'd0);
        upd(16'h0010, 6'd0, 1'b0);
        upd(16'h0010, 6'd0, 1'b1);
        look(16'h0010, 4'b0001);
        chk("bim.floor", 16'(b_taken), 16'd0);
        for (int k = 0; k < 4; k++) upd(16'h0010, 6'd0, 1'b1);
        upd(16'h0010, 6'd0, 1'b0);
        look(16'h0010, 4'b0001);
        chk("bim.cap", 16'(b_taken), 16'd1);
        upd(16'h0010, 6'd0, 1'b0);
        look(16'h0010, 4'b0001);
        chk("bim.cap_dn", 16'(b_taken), 16'd0);

        // Gshare separates the same PC under different histories
        do_reset();
        upd(16'h0020, 6'b000000, 1'b1);
        upd(16'h0020, 6'b000000, 1'b1);
        upd(16'h0020, 6'b000001, 1'b0);
        upd(16'h0020, 6'b000001, 1'b0);
        look(16'h0020, 4'b0001);
        chk("gs.h0.taken", 16'(g_taken), 16'd1);
        chk("gs.h0.ghr",   16'(g_ghr),   16'd0);
        look(16'h0020, 4'b0001);
        chk("gs.h1.taken", 16'(g_taken), 16'd0);
        chk("gs.h1.ghr",   16'(g_ghr),   16'd1);

        // Speculative shift, then recovery overriding a same-cycle shift
        do_reset();
        look(16'h0030, 4'b0001);
        look(16'h0030, 4'b0001);
        step(1'b0, 1'b1, 16'h0030, 4'b0001, 1'b1, 16'h0005, 6'b000001, 1'b0, 1'b1);
        chk("rec.spec_ghr", 16'(g_ghr), 16'b000011);
        look(16'h0000, 4'b0001);
        chk("rec.g_ghr", 16'(g_ghr), 16'b000010);
        chk("rec.b_ghr", 16'(b_ghr), 16'b000010);

        // Read-before-write on the same index
        do_reset();
        upd(16'h0008, 6'd0, 1'b0);
        step(1'b0, 1'b1, 16'h0008, 4'b0001, 1'b1, 16'h0008, 6'd0, 1'b1, 1'b0);
        chk("rbw.b_old", 16'(b_taken), 16'd0);
        chk("rbw.g_old", 16'(g_taken), 16'd0);
        look(16'h0008, 4'b0001);
        chk("rbw.b_new", 16'(b_taken), 16'd1);
        chk("rbw.g_new", 16'(g_taken), 16'd1);

        // Sparse mask with slot 1 not-taken and slot 3 taken
        do_reset();
        upd(16'h0041, 6'd0, 1'b0);
        look(16'h0040, 4'b1010);
        chk("mask.b_taken", 16'(b_taken), 16'b1000);
        chk("mask.b_sel",   16'(b_sel),   16'd3);
        chk("mask.g_taken", 16'(g_taken), 16'b1000);
        chk("mask.g_sel",   16'(g_sel),   16'd3);

        // Reset in the middle of traffic
        look(16'h0041, 4'b0001);
        step(1'b1, 1'b1, 16'h0041, 4'b0001, 1'b1, 16'h0041, 6'd0, 1'b0, 1'b1);
        chk("mid.vld",   16'(g_vld),   16'd0);
        chk("mid.taken", 16'(b_taken), 16'd0);
        look(16'h0041, 4'b0001);
        chk("mid.init",  16'(b_taken), 16'd1);
        chk("mid.ghr",   16'(g_ghr),   16'd0);

        // Random traffic, including PCs near the 16-bit wrap
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom_range(0, 16'hFFFF)),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 127)),
                 6'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
